mem_arbiter: RTL
================

# mem_arbiter

Shares the single data/instruction memory port between the instruction-fetch requester (IFU, driven by `pc`) and the load/store requester (LSU, driven by ALU `result`, `src2`, `wmask`, `rmask`). This enables the multi-cycle core variant with a variable-latency memory model.
- One transaction is outstanding at a time.
- Each transaction is completed by a response pulse to its owner, or by a watchdog timeout.

## Interface
- `MAX_WAIT`, default 255: cycles in REQ+WAIT before the watchdog aborts a transaction (range 1..255).
- `ERR_DATA`, default 32'hdeadbeaf: rdata returned on timeout.
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: reset is synchronous and active-high.
- `ifu_req` in 1: fetch request.
- `ifu_addr` in 32: fetch address.
- `ifu_gnt` out 1: fetch request accepted this cycle.
- `ifu_rvalid` out 1: fetch response pulse.
- `ifu_rdata` out 32: fetched instruction.
- `lsu_req` in 1: load/store request.
- `lsu_wen` in 1: 1 = store, 0 = load.
- `lsu_addr` in 32: load/store address.
- `lsu_wdata` in 32: store data.
- `lsu_wmask` in 8: store byte mask.
- `lsu_rmask` in 3: load size/sign code.
- `lsu_gnt` out 1: load/store request accepted this cycle.
- `lsu_rvalid` out 1: response pulse; loads carry data, stores act as an ack.
- `lsu_rdata` out 32: load data.
- `bus_err` out 1: pulses with rvalid when the transaction timed out.
- `mem_req`, `mem_wen` out 1: request and write enable to memory.
- `mem_addr`, `mem_wdata` out 32: registered request address and write data.
- `mem_wmask` out 8, `mem_rmask` out 3: registered request masks.
- `mem_gnt` in 1: memory accepted `mem_req`.
- `mem_rvalid` in 1: memory response valid.
- `mem_rdata` in 32: memory response data.

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - If any request is present, pick a winner and assert its `*_gnt` combinationally, in the same cycle, for exactly one cycle.
  - Latch the winner's fields into the `mem_*` registers and record the owner (IFU/LSU). Next state is REQ.
  - IFU requests drive `mem_wen`=0, `mem_wmask`=0, `mem_rmask`=3'b010 (word).
- REQ: `mem_req`=1 with stable fields until `mem_gnt`=1, then go to WAIT. `mem_rvalid` is ignored in REQ.
- WAIT: on `mem_rvalid`=1, latch `mem_rdata` and go to RESP.
- RESP:
  - Owner's `*_rvalid`=1 for one cycle; its `*_rdata` holds the latched data.
  - The non-owner's rdata holds its previous value.
  - Next state is IDLE.
- Watchdog:
  - An 8-bit counter clears on entry to REQ and increments each cycle in REQ/WAIT.
  - When the count equals `MAX_WAIT-1` and no `mem_rvalid` arrives, go to RESP with rdata=`ERR_DATA` and `bus_err`=1.
  - A `mem_rvalid` in that same cycle takes precedence over the timeout.
- Requesters may drop `req` after their `gnt`. A requester whose `req` falls without a `gnt` loses nothing; no request state is held.
- `mem_rvalid`/`mem_gnt` in IDLE or RESP (stray or post-reset) are ignored.

## Timing
- Reset: state IDLE; all gnt/rvalid/`bus_err`/`mem_req`/`mem_wen` = 0; `mem_addr`, `mem_wdata`, `mem_wmask`, `mem_rmask`, both rdata and the counter = 0; priority pointer = IFU-last (LSU favoured first).
- Best case: gnt at cycle N; `mem_req` at N+1; `mem_gnt` at N+1 gives WAIT at N+2; `mem_rvalid` at N+2 gives RESP (`*_rvalid`) at N+3; next gnt possible at N+4.
- Back-to-back throughput is therefore 1 transaction per 4 cycles minimum.
- Reset asserted in any state aborts the transaction: no rvalid is issued and the owner is lost. Requesters reissue after reset.
- Simultaneous `ifu_req` and `lsu_req` in IDLE: the winner is given by Configuration; exactly one gnt asserts.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined:
  - A 1-bit pointer records the last owner, updated at each gnt.
  - On a simultaneous request, the requester that was not last owner wins.
- Undefined: fixed priority, LSU always beats IFU. The pointer is not implemented.

## Test plan
- Lone fetch: `ifu_req`=1, `ifu_addr`=0x80000000; memory `mem_gnt` immediately, `mem_rvalid` 1 cycle later with 0x00000413.
  - Expect `ifu_gnt` at N, `mem_req` at N+1 with addr 0x80000000 and wen 0.
  - Expect `ifu_rvalid`=1 with rdata 0x00000413 at N+3 and `lsu_rvalid`=0.
- Store: `lsu_wen`=1, addr 0x80001000, wdata 0x12345678, wmask 0x0F; memory delays `mem_gnt` 3 cycles.
  - Expect `mem_*` fields stable during the hold and `lsu_rvalid` ack after `mem_rvalid`.
- Contention: both requesters held continuously for 4 transactions.
  - Fixed priority: 4 LSU grants, 0 IFU grants.
  - `ARB_ROUND_ROBIN_EN`: grants LSU, IFU, LSU, IFU.
- Timeout: `MAX_WAIT`=8, memory never asserts `mem_rvalid`.
  - Expect owner `rvalid` with rdata 0xdeadbeaf and `bus_err`=1 after 8 cycles in REQ/WAIT, then IDLE.
- Reset mid-WAIT: assert `rst` one cycle, then `mem_rvalid`=1 arrives.
  - Expect no rvalid, all outputs 0, state IDLE, and a new `ifu_req` granted in the next cycle.
- Stray `mem_rvalid` in IDLE with no requests: no rvalid, no state change.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the IFU, LSU and memory-side handshake signals of
// the memory arbiter. The slave modport is the arbiter's view; the master
// modport is the environment (requesters plus memory) driving it.
interface mem_arbiter_if;
    // Instruction-fetch requester
    logic        ifu_req;
    logic [31:0] ifu_addr;
    logic        ifu_gnt;
    logic        ifu_rvalid;
    logic [31:0] ifu_rdata;

    // Load/store requester
    logic        lsu_req;
    logic        lsu_wen;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic [7:0]  lsu_wmask;
    logic [2:0]  lsu_rmask;
    logic        lsu_gnt;
    logic        lsu_rvalid;
    logic [31:0] lsu_rdata;

    // Timeout indication, pulses together with the owner's rvalid
    logic        bus_err;

    // Shared memory port
    logic        mem_req;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic [2:0]  mem_rmask;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport slave (
        input  ifu_req, ifu_addr,
        input  lsu_req, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask, lsu_rmask,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output ifu_gnt, ifu_rvalid, ifu_rdata,
        output lsu_gnt, lsu_rvalid, lsu_rdata,
        output bus_err,
        output mem_req, mem_wen, mem_addr, mem_wdata, mem_wmask, mem_rmask
    );

    modport master (
        output ifu_req, ifu_addr,
        output lsu_req, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask, lsu_rmask,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  ifu_gnt, ifu_rvalid, ifu_rdata,
        input  lsu_gnt, lsu_rvalid, lsu_rdata,
        input  bus_err,
        input  mem_req, mem_wen, mem_addr, mem_wdata, mem_wmask, mem_rmask
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the instruction fetch unit and
// the load/store unit. One transaction is in flight at a time; each completes
// with a one-cycle rvalid to its owner or with a watchdog timeout (bus_err).
// Optional feature: define ARB_ROUND_ROBIN_EN for alternating priority on
// simultaneous requests; otherwise LSU always wins.
// Legal MAX_WAIT range is 1..255 (8-bit watchdog counter).
module mem_arbiter #(
    parameter int unsigned MAX_WAIT = 255,
    parameter logic [31:0] ERR_DATA = 32'hdeadbeaf
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    // Owner encoding doubles as index into the per-requester vectors
    localparam logic OWNER_IFU = 1'b0;
    localparam logic OWNER_LSU = 1'b1;

    localparam logic [7:0] WAIT_LAST  = 8'(MAX_WAIT - 1);
    localparam logic [2:0] RMASK_WORD = 3'b010;

    logic [1:0]  state_reg, state_next;
    logic        owner_reg, owner_next;
    logic [7:0]  wd_cnt_reg, wd_cnt_next;
    logic        err_reg, err_next;

    logic        mem_wen_reg, mem_wen_next;
    logic [31:0] mem_addr_reg, mem_addr_next;
    logic [31:0] mem_wdata_reg, mem_wdata_next;
    logic [7:0]  mem_wmask_reg, mem_wmask_next;
    logic [2:0]  mem_rmask_reg, mem_rmask_next;

    logic [1:0]  req_vec;
    logic [1:0]  gnt_vec;
    logic [1:0]  rvalid_vec;
    logic [31:0] rdata_vec [2];

    logic        any_req;
    logic        grant;
    logic        winner;
    logic        wd_expired;
    logic        resp_load;
    logic [31:0] resp_data;

    assign req_vec    = {bus.lsu_req, bus.ifu_req};
    assign any_req    = |req_vec;
    // No grant while reset is asserted: it would be lost with the FSM state
    assign grant      = (state_reg == ST_IDLE) && any_req && !rst;
    assign wd_expired = (wd_cnt_reg == WAIT_LAST);

`ifdef ARB_ROUND_ROBIN_EN
    logic last_owner_reg;

    // Remember the most recent grant winner for alternating priority
    always_ff @(posedge clk) begin
        if (rst) begin
            last_owner_reg <= OWNER_IFU;
        end else if (grant) begin
            last_owner_reg <= winner;
        end
    end

    // Winner selection: on contention, whoever did not win last time
    always_comb begin
        winner = OWNER_LSU;
        if (bus.lsu_req && bus.ifu_req) begin
            winner = (last_owner_reg == OWNER_LSU) ? OWNER_IFU : OWNER_LSU;
        end else if (bus.ifu_req) begin
            winner = OWNER_IFU;
        end
    end
`else
    // Winner selection: fixed priority, LSU beats IFU
    always_comb begin
        winner = OWNER_LSU;
        if (!bus.lsu_req && bus.ifu_req) begin
            winner = OWNER_IFU;
        end
    end
`endif

    // Transaction FSM, request capture and watchdog next-state logic
    always_comb begin
        state_next     = state_reg;
        owner_next     = owner_reg;
        wd_cnt_next    = wd_cnt_reg;
        err_next       = err_reg;
        mem_wen_next   = mem_wen_reg;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        mem_wmask_next = mem_wmask_reg;
        mem_rmask_next = mem_rmask_reg;
        resp_load      = 1'b0;
        resp_data      = bus.mem_rdata;

        case (state_reg)
            ST_IDLE: begin
                if (grant) begin
                    state_next  = ST_REQ;
                    owner_next  = winner;
                    wd_cnt_next = 8'd0;
                    err_next    = 1'b0;
                    if (winner == OWNER_LSU) begin
                        mem_wen_next   = bus.lsu_wen;
                        mem_addr_next  = bus.lsu_addr;
                        mem_wdata_next = bus.lsu_wdata;
                        mem_wmask_next = bus.lsu_wmask;
                        mem_rmask_next = bus.lsu_rmask;
                    end else begin
                        // Fetches are always full-word reads
                        mem_wen_next   = 1'b0;
                        mem_addr_next  = bus.ifu_addr;
                        mem_wdata_next = 32'd0;
                        mem_wmask_next = 8'd0;
                        mem_rmask_next = RMASK_WORD;
                    end
                end
            end

            ST_REQ: begin
                wd_cnt_next = wd_cnt_reg + 8'd1;
                // A response can't be legitimate before the request is taken
                if (wd_expired) begin
                    state_next = ST_RESP;
                    err_next   = 1'b1;
                    resp_load  = 1'b1;
                    resp_data  = ERR_DATA;
                end else if (bus.mem_gnt) begin
                    state_next = ST_WAIT;
                end
            end

            ST_WAIT: begin
                wd_cnt_next = wd_cnt_reg + 8'd1;
                // A real response beats a timeout landing in the same cycle
                if (bus.mem_rvalid) begin
                    state_next = ST_RESP;
                    resp_load  = 1'b1;
                    resp_data  = bus.mem_rdata;
                end else if (wd_expired) begin
                    state_next = ST_RESP;
                    err_next   = 1'b1;
                    resp_load  = 1'b1;
                    resp_data  = ERR_DATA;
                end
            end

            ST_RESP: begin
                state_next = ST_IDLE;
                err_next   = 1'b0;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State and memory-request registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            owner_reg     <= OWNER_IFU;
            wd_cnt_reg    <= 8'd0;
            err_reg       <= 1'b0;
            mem_wen_reg   <= 1'b0;
            mem_addr_reg  <= 32'd0;
            mem_wdata_reg <= 32'd0;
            mem_wmask_reg <= 8'd0;
            mem_rmask_reg <= 3'd0;
        end else begin
            state_reg     <= state_next;
            owner_reg     <= owner_next;
            wd_cnt_reg    <= wd_cnt_next;
            err_reg       <= err_next;
            mem_wen_reg   <= mem_wen_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            mem_wmask_reg <= mem_wmask_next;
            mem_rmask_reg <= mem_rmask_next;
        end
    end

    // Per-requester response channels: grant, rvalid and held read data
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
        logic [31:0] rdata_reg;

        assign gnt_vec[gi]    = grant && (winner == 1'(gi));
        assign rvalid_vec[gi] = (state_reg == ST_RESP) && (owner_reg == 1'(gi));
        assign rdata_vec[gi]  = rdata_reg;

        // Only the owner's data register is updated; the other holds
        always_ff @(posedge clk) begin
            if (rst) begin
                rdata_reg <= 32'd0;
            end else if (resp_load && (owner_reg == 1'(gi))) begin
                rdata_reg <= resp_data;
            end
        end
    end

    assign bus.ifu_gnt    = gnt_vec[OWNER_IFU];
    assign bus.lsu_gnt    = gnt_vec[OWNER_LSU];
    assign bus.ifu_rvalid = rvalid_vec[OWNER_IFU];
    assign bus.lsu_rvalid = rvalid_vec[OWNER_LSU];
    assign bus.ifu_rdata  = rdata_vec[OWNER_IFU];
    assign bus.lsu_rdata  = rdata_vec[OWNER_LSU];
    // err_reg is only ever set while in RESP
    assign bus.bus_err    = err_reg;

    assign bus.mem_req    = (state_reg == ST_REQ);
    assign bus.mem_wen    = mem_wen_reg;
    assign bus.mem_addr   = mem_addr_reg;
    assign bus.mem_wdata  = mem_wdata_reg;
    assign bus.mem_wmask  = mem_wmask_reg;
    assign bus.mem_rmask  = mem_rmask_reg;

endmodule
